arbiter_resp_ctrl: RTL and testbench

Control and return-path half of the I/D-cache to L2 arbiter. Decides which cache owns the shared L2 port and drives arbiter_sel to the request-side arbiter datapath. Routes l2_mem_resp and l2_mem_rdata back to the owning cache. Holds ownership for the full transaction and bounds data-side bursts so instruction fetch cannot starve.

---
 rtl/lc3b_types.sv | 20 ++
 rtl/arb_perf_counters.sv | 42 ++++
 rtl/arbiter_resp_ctrl.sv | 143 ++++++++++++++
 tb/tb_arbiter_resp_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b memory-side types plus the state encoding and select constants of the L2 arbiter.
package lc3b_types;

    typedef logic [127:0] lc3b_mem_data;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_SERVE_I = 2'd1,
        ARB_SERVE_D = 2'd2
    } arb_state_t;

    localparam logic ARB_SEL_I = 1'b0;
    localparam logic ARB_SEL_D = 1'b1;

    // Saturating increment for the 4-bit data-burst counter.
    function automatic logic [3:0] sat_inc4(input logic [3:0] value);
        return (value == 4'hF) ? value : value + 4'd1;
    endfunction

endpackage

// File: rtl/arb_perf_counters.sv
// Grant and conflict event counters for the L2 arbiter; only built when ARB_PERF_CNT_EN is defined.
`ifdef ARB_PERF_CNT_EN
module arb_perf_counters (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic        start_d,
    input  logic        conflict,
    output logic [15:0] perf_i_grants,
    output logic [15:0] perf_d_grants,
    output logic [15:0] perf_conflict_cycles
);

    logic [15:0] i_grants_r;
    logic [15:0] d_grants_r;
    logic [15:0] conflict_r;

    // Free-running wrapping event counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_grants_r <= 16'd0;
            d_grants_r <= 16'd0;
            conflict_r <= 16'd0;
        end else begin
            if (start_i) begin
                i_grants_r <= i_grants_r + 16'd1;
            end
            if (start_d) begin
                d_grants_r <= d_grants_r + 16'd1;
            end
            if (conflict) begin
                conflict_r <= conflict_r + 16'd1;
            end
        end
    end

    assign perf_i_grants        = i_grants_r;
    assign perf_d_grants        = d_grants_r;
    assign perf_conflict_cycles = conflict_r;

endmodule
`endif

// File: rtl/arbiter_resp_ctrl.sv
// Ownership FSM and response return path for the I/D-cache to L2 arbiter.
// Defining ARB_PERF_CNT_EN adds grant/conflict performance counter ports.
module arbiter_resp_ctrl
    import lc3b_types::*;
#(
    parameter int MAX_D_BURST = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_pmem_read,
    input  logic         i_pmem_write,
    input  logic         d_pmem_read,
    input  logic         d_pmem_write,
    input  logic         l2_mem_resp,
    input  lc3b_mem_data l2_mem_rdata,
    output logic         arbiter_sel,
    output logic         i_pmem_resp,
    output lc3b_mem_data i_pmem_rdata,
    output logic         d_pmem_resp,
    output lc3b_mem_data d_pmem_rdata
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [15:0]  perf_i_grants,
    output logic [15:0]  perf_d_grants,
    output logic [15:0]  perf_conflict_cycles
`endif
);

    localparam logic [3:0] MAX_BURST_C = 4'(MAX_D_BURST);

    arb_state_t state_r;
    logic [3:0] burst_cnt_r;
    logic       i_req_s;
    logic       d_req_s;
    logic       grant_valid_s;
    logic       grant_d_s;

    assign i_req_s = i_pmem_read | i_pmem_write;
    assign d_req_s = d_pmem_read | d_pmem_write;

    // Arbitration: D wins unless I is waiting and D has used up its burst allowance.
    always_comb begin
        grant_valid_s = 1'b0;
        grant_d_s     = 1'b0;
        if (d_req_s && !(i_req_s && (burst_cnt_r >= MAX_BURST_C))) begin
            grant_valid_s = 1'b1;
            grant_d_s     = 1'b1;
        end else if (i_req_s) begin
            grant_valid_s = 1'b1;
            grant_d_s     = 1'b0;
        end else begin
            grant_valid_s = 1'b0;
            grant_d_s     = 1'b0;
        end
    end

    // Ownership FSM; a dropped request never aborts, only l2_mem_resp ends a transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ARB_IDLE;
            burst_cnt_r <= 4'd0;
        end else begin
            case (state_r)
                ARB_IDLE: begin
                    if (grant_valid_s) begin
                        state_r <= grant_d_s ? ARB_SERVE_D : ARB_SERVE_I;
                    end else begin
                        state_r <= ARB_IDLE;
                    end
                end
                ARB_SERVE_I: begin
                    if (l2_mem_resp) begin
                        state_r     <= ARB_IDLE;
                        burst_cnt_r <= 4'd0;
                    end else begin
                        state_r <= ARB_SERVE_I;
                    end
                end
                ARB_SERVE_D: begin
                    if (l2_mem_resp) begin
                        state_r     <= ARB_IDLE;
                        burst_cnt_r <= i_req_s ? sat_inc4(burst_cnt_r) : 4'd0;
                    end else begin
                        state_r <= ARB_SERVE_D;
                    end
                end
                default: begin
                    state_r     <= ARB_IDLE;
                    burst_cnt_r <= 4'd0;
                end
            endcase
        end
    end

    // Select and zero-latency response steering; the non-owner always sees zeros.
    always_comb begin
        arbiter_sel  = ARB_SEL_I;
        i_pmem_resp  = 1'b0;
        i_pmem_rdata = '0;
        d_pmem_resp  = 1'b0;
        d_pmem_rdata = '0;
        case (state_r)
            ARB_IDLE: begin
                arbiter_sel = grant_d_s ? ARB_SEL_D : ARB_SEL_I;
            end
            ARB_SERVE_I: begin
                arbiter_sel  = ARB_SEL_I;
                i_pmem_resp  = l2_mem_resp;
                i_pmem_rdata = l2_mem_rdata;
            end
            ARB_SERVE_D: begin
                arbiter_sel  = ARB_SEL_D;
                d_pmem_resp  = l2_mem_resp;
                d_pmem_rdata = l2_mem_rdata;
            end
            default: begin
                arbiter_sel = ARB_SEL_I;
            end
        endcase
    end

`ifdef ARB_PERF_CNT_EN
    logic start_i_s;
    logic start_d_s;
    logic conflict_s;

    assign start_i_s  = (state_r == ARB_IDLE) & grant_valid_s & ~grant_d_s;
    assign start_d_s  = (state_r == ARB_IDLE) & grant_valid_s & grant_d_s;
    assign conflict_s = i_req_s & d_req_s & (state_r != ARB_IDLE);

    arb_perf_counters u_perf (
        .clk                  (clk),
        .rst_n                (rst_n),
        .start_i              (start_i_s),
        .start_d              (start_d_s),
        .conflict             (conflict_s),
        .perf_i_grants        (perf_i_grants),
        .perf_d_grants        (perf_d_grants),
        .perf_conflict_cycles (perf_conflict_cycles)
    );
`endif

endmodule

// File: tb/tb_arbiter_resp_ctrl.sv
// Directed self-checking bench for arbiter_resp_ctrl; inputs change 1 ns after posedge, outputs sampled 2 ns later.
module tb_arbiter_resp_ctrl;
    import lc3b_types::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         i_pmem_read, i_pmem_write, d_pmem_read, d_pmem_write;
    logic         l2_mem_resp;
    lc3b_mem_data l2_mem_rdata;
    logic         arbiter_sel, i_pmem_resp, d_pmem_resp;
    lc3b_mem_data i_pmem_rdata, d_pmem_rdata;
`ifdef ARB_PERF_CNT_EN
    logic [15:0]  perf_i_grants, perf_d_grants, perf_conflict_cycles;
`endif

    int checks = 0;
    int errors = 0;
    lc3b_mem_data pat;

    arbiter_resp_ctrl #(.MAX_D_BURST(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_pmem_read  (i_pmem_read),
        .i_pmem_write (i_pmem_write),
        .d_pmem_read  (d_pmem_read),
        .d_pmem_write (d_pmem_write),
        .l2_mem_resp  (l2_mem_resp),
        .l2_mem_rdata (l2_mem_rdata),
        .arbiter_sel  (arbiter_sel),
        .i_pmem_resp  (i_pmem_resp),
        .i_pmem_rdata (i_pmem_rdata),
        .d_pmem_resp  (d_pmem_resp),
        .d_pmem_rdata (d_pmem_rdata)
`ifdef ARB_PERF_CNT_EN
        ,
        .perf_i_grants        (perf_i_grants),
        .perf_d_grants        (perf_d_grants),
        .perf_conflict_cycles (perf_conflict_cycles)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One cycle: drive inputs just after the edge, then settle before sampling.
    task automatic drive(input logic ir, input logic iw, input logic dr, input logic dw,
                         input logic l2r, input logic [127:0] rd);
        @(posedge clk);
        #1;
        i_pmem_read  = ir;
        i_pmem_write = iw;
        d_pmem_read  = dr;
        d_pmem_write = dw;
        l2_mem_resp  = l2r;
        l2_mem_rdata = rd;
        #2;
    endtask

    initial begin
        rst_n = 1'b0;
        i_pmem_read = 1'b0; i_pmem_write = 1'b0;
        d_pmem_read = 1'b0; d_pmem_write = 1'b0;
        l2_mem_resp = 1'b0; l2_mem_rdata = '0;
        #2;
        // 1: reset state, then a stray L2 response in IDLE
        check("rst_sel", arbiter_sel, 1'b0);
        check("rst_iresp", i_pmem_resp, 1'b0);
        check("rst_dresp", d_pmem_resp, 1'b0);
        check("rst_irdata", i_pmem_rdata, 128'd0);
        check("rst_drdata", d_pmem_rdata, 128'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, {4{32'hDEADBEEF}});
        check("idle_stray_iresp", i_pmem_resp, 1'b0);
        check("idle_stray_dresp", d_pmem_resp, 1'b0);
        check("idle_stray_irdata", i_pmem_rdata, 128'd0);

        // 2: lone I read, response on the fifth owned cycle
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        check("iread_grant_sel", arbiter_sel, 1'b0);
        for (int c = 0; c < 4; c++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
            check("iread_wait_sel", arbiter_sel, 1'b0);
            check("iread_wait_resp", i_pmem_resp, 1'b0);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, {16{8'hA5}});
        check("iread_resp", i_pmem_resp, 1'b1);
        check("iread_rdata", i_pmem_rdata, {16{8'hA5}});
        check("iread_dresp", d_pmem_resp, 1'b0);
        check("iread_drdata", d_pmem_rdata, 128'd0);
        check("iread_sel", arbiter_sel, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, {16{8'h5A}});
        check("iread_back_idle", i_pmem_resp, 1'b0);

        // 3: simultaneous I and D -> four D grants, then I forced
        for (int k = 0; k < 4; k++) begin
            pat = {120'd0, 8'(k + 1)};
            drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0);
            check("burst_idle_sel_d", arbiter_sel, 1'b1);
            drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, pat);
            check("burst_dresp", d_pmem_resp, 1'b1);
            check("burst_drdata", d_pmem_rdata, pat);
            check("burst_iresp", i_pmem_resp, 1'b0);
        end
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        check("burst_force_i_sel", arbiter_sel, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, {8{16'h1234}});
        check("burst_force_iresp", i_pmem_resp, 1'b1);
        check("burst_force_dresp", d_pmem_resp, 1'b0);
        check("burst_force_irdata", i_pmem_rdata, {8{16'h1234}});

        // 4: D write owns the port while an I read arrives
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        check("dwr_grant_sel", arbiter_sel, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        check("dwr_hold_sel", arbiter_sel, 1'b1);
        check("dwr_hold_iresp", i_pmem_resp, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        check("dwr_hold_sel2", arbiter_sel, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, {4{32'hC0FFEE00}});
        check("dwr_resp", d_pmem_resp, 1'b1);
        check("dwr_resp_sel", arbiter_sel, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        check("dwr_then_i_sel", arbiter_sel, 1'b0);
        check("dwr_then_i_noresp", i_pmem_resp, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, {4{32'h0BADF00D}});
        check("dwr_then_i_resp", i_pmem_resp, 1'b1);
        check("dwr_then_i_rdata", i_pmem_rdata, {4{32'h0BADF00D}});
        check("dwr_then_i_dresp", d_pmem_resp, 1'b0);

        // 5: asynchronous reset while D is waiting for its response
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        check("arst_grant_sel", arbiter_sel, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        check("arst_serve_sel", arbiter_sel, 1'b1);
        @(posedge clk);
        #1;
        l2_mem_resp  = 1'b1;
        l2_mem_rdata = {4{32'h77777777}};
        #1;
        check("arst_pre_dresp", d_pmem_resp, 1'b1);
        rst_n       = 1'b0;
        d_pmem_read = 1'b0;
        #1;
        check("arst_dresp", d_pmem_resp, 1'b0);
        check("arst_drdata", d_pmem_rdata, 128'd0);
        check("arst_sel", arbiter_sel, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        #2;
        check("arst_late_dresp", d_pmem_resp, 1'b0);
        check("arst_late_iresp", i_pmem_resp, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);

`ifdef ARB_PERF_CNT_EN
        // 6: three I and two D grants with six overlap cycles outside IDLE
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, '0);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, '0);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, '0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, '0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, '0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        check("perf_i_grants", perf_i_grants, 16'd3);
        check("perf_d_grants", perf_d_grants, 16'd2);
        check("perf_conflict_cycles", perf_conflict_cycles, 16'd6);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
